pc_fetch_unit: RTL and testbench

//  PC register and instruction-fetch sequencer for the RV32I core.
//  - Holds the architectural PC and issues one request at a time to instruction memory.
//  - Presents each fetched instruction to decode/execute and holds it until the consumer releases it.
//  - Takes Branch_taken from the branch comparator, plus jump/JALR decode, and selects the next PC.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 35 +++
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I fetch definitions: FSM states, instruction constants and alignment helper.
// Pure declarations; no timing or flow control of its own.
package rv_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  // RV32I without the C extension needs word-aligned fetch targets.
  function automatic logic target_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the held instruction: jalr > jal > taken branch > sequential.
// Purely combinational, zero latency; no flow control.
module next_pc_calc
  import rv_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] jalr_sum;
  logic [31:0] rel_target;
  logic [31:0] seq_target;

  assign jalr_sum   = rs1_data + imm;
  assign rel_target = instr_pc + imm;
  assign seq_target = instr_pc + 32'd4;

  always_comb begin
    next_pc = seq_target;
    if (jalr) begin
      next_pc = jalr_sum & ~32'h1;
    end else if (jal || branch_taken) begin
      next_pc = rel_target;
    end
  end

  assign misaligned = target_misaligned(next_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch sequencer; request-to-instr_valid latency is 2 cycles minimum.
// Holds the fetched instruction while stall=1; memory backpressure via imem_ready, response via imem_rvalid.
module pc_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         drop;
  logic [31:0]  next_pc;
  logic         next_misaligned;
  logic         req_in_flight;

  next_pc_calc u_next_pc_calc (
    .instr_pc     (instr_pc),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misaligned   (next_misaligned)
  );

  assign imem_addr = pc;

  // A flush that lands while memory owes us a response must wait for it, so that
  // only one request is ever outstanding; the stale word is then silently dropped.
  assign req_in_flight = ((state == S_WAIT) && !imem_rvalid) ||
                         ((state == S_REQ) && imem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else if (flush) begin
      pc          <= flush_pc;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      if (req_in_flight) begin
        state    <= S_WAIT;
        drop     <= 1'b1;
        imem_req <= 1'b0;
      end else begin
        state    <= S_REQ;
        drop     <= 1'b0;
        imem_req <= 1'b1;
      end
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              state    <= S_HALT;
              misalign <= 1'b1;
            end else begin
              pc       <= next_pc;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then randomized control-flow traffic against
// a transaction-level model (expected fetch PC sequence plus a hashed memory image).
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;
  int resp_delay = 0;
  bit rnd_delay  = 0;
  bit rnd_ready  = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic j, input logic jr,
                                             input logic b, input logic [31:0] im, input logic [31:0] rs);
    if (jr) return (rs + im) & 32'hFFFF_FFFE;
    if (j || b) return pc + im;
    return pc + 32'd4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) imem_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 80) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  task automatic release_hold(input logic j, input logic jr, input logic b,
                              input logic [31:0] im, input logic [31:0] rs);
    jal = j; jalr = jr; branch_taken = b; imm = im; rs1_data = rs; stall = 1'b0;
    tick();
    stall = 1'b1; jal = 1'b0; jalr = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] a);
    flush = 1'b1; flush_pc = a;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_mis"},   32'(misalign),    32'd0);
    check({tag, "_instr"}, instr,            32'h0000_0013);
    check({tag, "_ipc"},   instr_pc,         32'h0000_0000);
    check({tag, "_addr"},  imem_addr,        32'h0000_0000);
  endtask

  // Memory responder: one response per accepted request, after a configurable delay.
  initial begin : mem_model
    logic [31:0] a;
    int d;
    bit aborted;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && imem_ready) begin
        a = imem_addr;
        d = rnd_delay ? $urandom_range(0, 3) : resp_delay;
        aborted = 1'b0;
        @(posedge clk);
        #1;
        while (d > 0) begin
          if (!rst_n) aborted = 1'b1;
          @(posedge clk);
          #1;
          d--;
        end
        if (!rst_n) aborted = 1'b1;
        if (!aborted) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(a);
          @(posedge clk);
          #1;
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] exp_pc, tgt, fp, im, rs, held_i, held_pc;
    logic j, jr, b;
    int sel, ns;

    rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'h0; rs1_data = 32'h0; flush = 1'b0; flush_pc = 32'h0; imem_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Boot: first request at RESET_PC, instr_valid three cycles after release
    rst_n = 1'b1;
    tick();
    check("boot_req1", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    tick();
    check("boot_req_wait", 32'(imem_req), 32'd0);
    check("boot_valid_early", 32'(instr_valid), 32'd0);
    tick();
    check("boot_valid", 32'(instr_valid), 32'd1);
    check("boot_instr", instr, mem_word(32'h0));
    check("boot_ipc", instr_pc, 32'h0);
    release_hold(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_valid_drop", 32'(instr_valid), 32'd0);
    check("seq_req", 32'(imem_req), 32'd1);
    check("seq_addr", imem_addr, 32'h4);

    // Taken and not-taken branch from 0x100
    wait_valid("seq4");
    flush_to(32'h100);
    wait_valid("br");
    check("br_ipc", instr_pc, 32'h100);
    release_hold(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
    wait_req("br_t");
    check("br_taken_addr", imem_addr, 32'h0F0);
    wait_valid("br_t");
    check("br_taken_ipc", instr_pc, 32'h0F0);
    flush_to(32'h100);
    wait_valid("br_nt");
    release_hold(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    wait_req("br_nt");
    check("br_nt_addr", imem_addr, 32'h104);

    // JALR: aligned after bit-0 mask, then bit-1 misaligned target halts fetch
    wait_valid("jalr");
    release_hold(1'b0, 1'b1, 1'b0, 32'h4, 32'h2001);
    wait_req("jalr");
    check("jalr_addr", imem_addr, 32'h2004);
    wait_valid("jalr2");
    release_hold(1'b1, 1'b1, 1'b1, 32'h4, 32'h2003);
    check("halt_mis", 32'(misalign), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_pc", imem_addr, 32'h2004);
    repeat (3) tick();
    check("halt_req_later", 32'(imem_req), 32'd0);
    check("halt_mis_later", 32'(misalign), 32'd1);
    flush_to(32'h300);
    check("unhalt_mis", 32'(misalign), 32'd0);
    check("unhalt_req", 32'(imem_req), 32'd1);
    check("unhalt_addr", imem_addr, 32'h300);

    // Stall holds everything while control inputs wiggle
    wait_valid("stall");
    held_i = instr; held_pc = instr_pc;
    for (int s = 0; s < 5; s++) begin
      branch_taken = ~branch_taken; jal = 1'(s & 1); imm = $urandom;
      tick();
      check("stall_instr", instr, held_i);
      check("stall_ipc", instr_pc, 32'h300);
      check("stall_pc", imem_addr, held_pc);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    jal = 1'b0; branch_taken = 1'b0;

    // Flush while waiting: stale response consumed, refetch at flush target
    resp_delay = 3;
    release_hold(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_req("fw");
    check("fw_addr", imem_addr, 32'h304);
    tick();
    flush_to(32'h8000);
    for (int s = 0; s < 3; s++) begin
      check("fw_no_req", 32'(imem_req), 32'd0);
      check("fw_no_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    wait_req("fw2");
    check("fw_refetch", imem_addr, 32'h8000);
    wait_valid("fw");
    check("fw_ipc", instr_pc, 32'h8000);
    check("fw_instr", instr, mem_word(32'h8000));

    // Flush coincident with rvalid: data dropped, request issued immediately
    resp_delay = 1;
    release_hold(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_req("fr");
    tick();
    tick();
    flush_to(32'h9000);
    check("fr_req", 32'(imem_req), 32'd1);
    check("fr_addr", imem_addr, 32'h9000);
    check("fr_valid", 32'(instr_valid), 32'd0);
    wait_valid("fr");
    check("fr_ipc", instr_pc, 32'h9000);

    // Asynchronous reset in the middle of a wait
    resp_delay = 4;
    release_hold(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_req("ar");
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    repeat (4) tick();
    rst_n = 1'b1;
    resp_delay = 0;
    wait_req("ar2");
    check("ar_addr", imem_addr, 32'h0);
    wait_valid("ar");
    check("ar_ipc", instr_pc, 32'h0);

    // Randomized control flow against the expected fetch-PC sequence
    flush_to(32'h1000);
    exp_pc = 32'h1000;
    rnd_ready = 1'b1;
    rnd_delay = 1'b1;
    for (int t = 0; t < 150; t++) begin
      wait_valid("rnd");
      check("rnd_ipc", instr_pc, exp_pc);
      check("rnd_instr", instr, mem_word(exp_pc));
      ns = $urandom_range(0, 3);
      for (int s = 0; s < ns; s++) begin
        branch_taken = 1'($urandom_range(0, 1));
        jal = 1'($urandom_range(0, 1));
        jalr = 1'($urandom_range(0, 1));
        tick();
        check("rnd_stall_ipc", instr_pc, exp_pc);
        check("rnd_stall_req", 32'(imem_req), 32'd0);
      end
      jal = 1'b0; jalr = 1'b0; branch_taken = 1'b0;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        fp = $urandom & 32'hFFFF_FFFC;
        flush_to(fp);
        exp_pc = fp;
      end else begin
        jr = (sel == 3) || (sel == 4);
        j  = (sel <= 2) || (jr && ($urandom_range(0, 1) == 1));
        b  = 1'($urandom_range(0, 1));
        im = ($urandom_range(0, 7) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
        rs = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
        tgt = ref_target(exp_pc, j, jr, b, im, rs);
        release_hold(j, jr, b, im, rs);
        if ((tgt & 32'h3) != 32'h0) begin
          check("rnd_mis", 32'(misalign), 32'd1);
          check("rnd_mis_req", 32'(imem_req), 32'd0);
          fp = $urandom & 32'hFFFF_FFFC;
          flush_to(fp);
          exp_pc = fp;
        end else begin
          check("rnd_no_mis", 32'(misalign), 32'd0);
          wait_req("rnd");
          check("rnd_addr", imem_addr, tgt);
          exp_pc = tgt;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
